regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 142 ++++++++++++++
 tb/tb_regfile_mp.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported integer register file with an issue scoreboard.
//   - two write ports (port 1 is the late load/CSR writeback and wins on a
//     same-address collision), NRD combinational read ports
//   - after reset an INIT sweep zeroes registers 1..NREGS-1, one per cycle;
//     ready rises when the sweep completes
//   - busy scoreboard: set at issue, cleared by writeback, bulk-cleared by flush
//   - optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the
//     read ports; without it reads return stored contents only
// Handshake note: there is no valid/ready flow control on the data paths.
// Writes and issues are single-cycle qualified strobes that are accepted
// unconditionally while ready=1 and dropped while ready=0.
// The FSM state is exported on state_dbg (0 = INIT, 1 = RUN).
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we0,
    input  logic [AW-1:0]       waddr0,
    input  logic [XLEN-1:0]     wdata0,
    input  logic                we1,
    input  logic [AW-1:0]       waddr1,
    input  logic [XLEN-1:0]     wdata1,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    output logic                ready,
    output logic [0:0]          state_dbg
);

    localparam logic [0:0]    ST_INIT  = 1'b0;
    localparam logic [0:0]    ST_RUN   = 1'b1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    logic [0:0]      state;
    logic [AW-1:0]   cnt;
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic            run;
    logic            wr0_ok;
    logic            wr1_ok;

    // Writes only count in RUN and never to the hardwired zero register.
    assign run       = (state == ST_RUN);
    assign wr0_ok    = run && we0 && (waddr0 != '0);
    assign wr1_ok    = run && we1 && (waddr1 != '0);
    assign ready     = run;
    assign state_dbg = state;

    // INIT/RUN sequencer: sweep counter walks 1..NREGS-1, then RUN until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= AW'(1);
        end else if (state == ST_INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
                state <= ST_RUN;
            end
        end
    end

    // Register storage: zero sweep in INIT, port 1 written last so it wins.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_INIT) begin
                regs[cnt] <= '0;
            end else begin
                if (wr0_ok) begin
                    regs[waddr0] <= wdata0;
                end
                if (wr1_ok) begin
                    regs[waddr1] <= wdata1;
                end
            end
        end
    end

    // Next scoreboard: flush, then writeback clears, then issue sets last so
    // a new producer issued in the same cycle keeps its register busy.
    always_comb begin
        busy_nxt = flush ? '0 : busy;
        if (wr0_ok) begin
            busy_nxt[waddr0] = 1'b0;
        end
        if (wr1_ok) begin
            busy_nxt[waddr1] = 1'b0;
        end
        if (iss_en && (iss_rd != '0)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register: cleared by reset, frozen (all zero) during INIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (run) begin
            busy <= busy_nxt;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        logic            rb;

        assign ra = raddr[k*AW +: AW];

        // Read mux: stored value, optional forwarding, zero in INIT / for x0.
        always_comb begin
            rd = regs[ra];
            rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr0_ok && (waddr0 == ra)) begin
                rd = wdata0;
                rb = 1'b0;
            end
            if (wr1_ok && (waddr1 == ra)) begin
                rd = wdata1;
                rb = 1'b0;
            end
`endif
            if (!run || (ra == '0)) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign rdata[k*XLEN +: XLEN] = rd;
        assign rbusy[k]              = rb;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp (default 32x32, 2 read ports).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// 2 units later, well before the next edge.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    // ---------------- clock / reset / DUT ----------------
    logic                clk = 1'b0;
    logic                rst_n;
    logic                we0, we1, iss_en, flush;
    logic [AW-1:0]       waddr0, waddr1, iss_rd;
    logic [XLEN-1:0]     wdata0, wdata1;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                ready;
    logic [0:0]          state_dbg;

    always #20 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush),
        .ready(ready), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [XLEN-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic push_exp(input logic [XLEN-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check_pop(input string name, input logic [XLEN-1:0] act);
        logic [XLEN-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: got 0x%0h, no expected value queued", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                failures++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, e);
            end
        end
    endtask

    task automatic expect_now(input string name, input logic [XLEN-1:0] act,
                              input logic [XLEN-1:0] e);
        push_exp(e);
        check_pop(name, act);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    // Counts INIT cycles until ready; optionally fires writes/issue mid-sweep.
    task automatic wait_ready(input bit inject, output int n);
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            if (inject && n == 24) begin
                we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'hCAFE_F00D;
                we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h0000_0001;
                iss_en = 1'b1; iss_rd = 5'd8;
            end
            step();
            n++;
            idle();
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic            we0;
        logic [AW-1:0]   wa0;
        logic [XLEN-1:0] wd0;
        logic            we1;
        logic [AW-1:0]   wa1;
        logic [XLEN-1:0] wd1;
        logic            iss;
        logic [AW-1:0]   ird;
        logic            fl;
        logic [AW-1:0]   ra0;
        logic [AW-1:0]   ra1;
        logic [XLEN-1:0] e0;
        logic [XLEN-1:0] e1;
        logic [1:0]      eb;
    } vec_t;

    localparam int NV = 15;
    vec_t vt[NV];

    initial begin : main
        int n;

        // No vector reads an address written in the same cycle, so every
        // expectation below holds with and without forwarding.
        vt[0]  = '{1'b1, 5'd10, 32'h1234_5678, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd1, 5'd2, 32'h0, 32'h0, 2'b00};
        vt[1]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'hA5A5_A5A5, 1'b0, 5'd0, 1'b0, 5'd10, 5'd0, 32'h1234_5678, 32'h0, 2'b00};
        vt[2]  = '{1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 1'b0, 5'd11, 5'd10, 32'hA5A5_A5A5, 32'h1234_5678, 2'b00};
        vt[3]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b0, 5'd7, 5'd1, 32'h22, 32'h0, 2'b00};
        vt[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd7, 32'h0, 32'h22, 2'b00};
        vt[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd9, 5'd0, 32'h0, 32'h0, 2'b01};
        vt[6]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3, 32'h0, 32'h0, 2'b00};
        vt[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd9, 5'd0, 32'h99, 32'h0, 2'b00};
        vt[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd3, 5'd9, 32'h0, 32'h99, 2'b01};
        vt[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd3, 5'd4, 32'h0, 32'h0, 2'b11};
        vt[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd4, 32'h0, 32'h0, 2'b10};
        vt[11] = '{1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd1, 5'd2, 32'h0, 32'h0, 2'b00};
        vt[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd4, 32'h55, 32'h0, 2'b11};
        vt[13] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 1'b1, 5'd1, 5'd2, 32'h0, 32'h0, 2'b00};
        vt[14] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd4, 32'h55, 32'h44, 2'b00};

        // ---- reset ----
        idle();
        set_rd(5'd16, 5'd3);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #2;
        expect_now("rst_ready", 32'(ready), 32'h0);
        expect_now("rst_rbusy", 32'(rbusy), 32'h0);
        expect_now("rst_rd0", rdata[XLEN-1:0], 32'h0);
        expect_now("rst_rd1", rdata[2*XLEN-1:XLEN], 32'h0);

        // ---- initial sweep length and all-zero first RUN cycle ----
        wait_ready(1'b0, n);
        expect_now("init_len", 32'(n), 32'd31);
        expect_now("run_state", 32'(state_dbg), 32'h1);
        for (int a = 0; a < NREGS / 2; a++) begin
            set_rd(AW'(2 * a), AW'(2 * a + 1));
            #1;
            expect_now($sformatf("zero_r%0d", 2 * a), rdata[XLEN-1:0], 32'h0);
            expect_now($sformatf("zero_r%0d", 2 * a + 1), rdata[2*XLEN-1:XLEN], 32'h0);
        end
        step();

        // ---- table-driven vectors ----
        for (int i = 0; i < NV; i++) begin
            we0 = vt[i].we0; waddr0 = vt[i].wa0; wdata0 = vt[i].wd0;
            we1 = vt[i].we1; waddr1 = vt[i].wa1; wdata1 = vt[i].wd1;
            iss_en = vt[i].iss; iss_rd = vt[i].ird; flush = vt[i].fl;
            set_rd(vt[i].ra0, vt[i].ra1);
            push_exp(vt[i].e0);
            push_exp(vt[i].e1);
            push_exp(32'(vt[i].eb));
            #2;
            check_pop($sformatf("vec%0d_rd0", i), rdata[XLEN-1:0]);
            check_pop($sformatf("vec%0d_rd1", i), rdata[2*XLEN-1:XLEN]);
            check_pop($sformatf("vec%0d_rbusy", i), 32'(rbusy));
            step();
        end
        idle();

        // ---- same-cycle write/read to reg 5 ----
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
        set_rd(5'd5, 5'd0);
        #2;
`ifdef REGFILE_BYPASS_EN
        expect_now("wr5_same", rdata[XLEN-1:0], 32'hDEAD_BEEF);
`else
        expect_now("wr5_same", rdata[XLEN-1:0], 32'h0);
`endif
        step();
        idle();
        #2;
        expect_now("wr5_next", rdata[XLEN-1:0], 32'hDEAD_BEEF);

        // ---- port 1 forwarded over port 0 on reg 6 ----
        we0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'h1;
        we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'h2;
        set_rd(5'd6, 5'd5);
        #2;
`ifdef REGFILE_BYPASS_EN
        expect_now("wr6_same", rdata[XLEN-1:0], 32'h2);
`else
        expect_now("wr6_same", rdata[XLEN-1:0], 32'h0);
`endif
        step();
        idle();
        #2;
        expect_now("wr6_next", rdata[XLEN-1:0], 32'h2);

        // ---- rbusy with a same-cycle writeback on reg 13 ----
        iss_en = 1'b1; iss_rd = 5'd13;
        step();
        idle();
        we0 = 1'b1; waddr0 = 5'd13; wdata0 = 32'h13;
        set_rd(5'd13, 5'd0);
        #2;
`ifdef REGFILE_BYPASS_EN
        expect_now("busy13_same", 32'(rbusy[0]), 32'h0);
`else
        expect_now("busy13_same", 32'(rbusy[0]), 32'h1);
`endif
        step();
        idle();
        #2;
        expect_now("busy13_next", 32'(rbusy[0]), 32'h0);
        expect_now("rd13_next", rdata[XLEN-1:0], 32'h13);

        // ---- reset pulse at sweep cycle 10, writes during INIT dropped ----
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 9; c++) begin
            step();
        end
        set_rd(5'd10, 5'd5);
        #2;
        expect_now("midinit_ready", 32'(ready), 32'h0);
        expect_now("midinit_rd0", rdata[XLEN-1:0], 32'h0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_ready(1'b1, n);
        expect_now("reinit_len", 32'(n), 32'd31);
        set_rd(5'd2, 5'd3);
        #2;
        expect_now("init_wr_r2", rdata[XLEN-1:0], 32'h0);
        expect_now("init_wr_r3", rdata[2*XLEN-1:XLEN], 32'h0);
        set_rd(5'd8, 5'd5);
        #2;
        expect_now("init_iss_r8", 32'(rbusy[0]), 32'h0);
        expect_now("swept_r5", rdata[2*XLEN-1:XLEN], 32'h0);

        expect_now("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the run never needs more than a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
